// File: rtl/boa_gpio_seq_pkg.sv
// Shared definitions for the boa_gpio_seq waveform sequencer: register map, CTRL bits, FSM states, step layout.
package boa_gpio_seq_pkg;

    localparam logic [8:0] ctrl_off      = 9'h000;
    localparam logic [8:0] status_off    = 9'h004;
    localparam logic [8:0] cfg_off       = 9'h008;
    localparam logic [8:0] prescale_off  = 9'h00C;
    localparam logic [8:0] step_base_off = 9'h100;

    localparam int ctrl_start_bit = 0;
    localparam int ctrl_busy_bit  = 0;
    localparam int ctrl_stop_bit  = 1;
    localparam int ctrl_arm_bit   = 2;
    localparam int ctrl_done_bit  = 8;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [15:0] dur;
        logic [7:0]  oe;
        logic [7:0]  value;
    } step_t;

endpackage

// File: rtl/boa_gpio_seq_if.sv
// Peripheral bus: word address, 4-bit byte-enable write strobe, registered read data, ready always high.
interface boa_mem_bus;

    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic [31:0] rdata;

    modport master (output valid, addr, wdata, we, input ready, rdata);
    modport MEM    (input valid, addr, wdata, we, output ready, rdata);

endinterface

// File: rtl/boa_gpio_seq_timer.sv
// Step timebase: prescaler counting 0..p, duration counter stepping on each prescaler wrap.
// step_end is high during the final cycle of a step, i.e. (d+1)*(p+1) cycles after clear.
module boa_gpio_seq_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clear,
    input  logic [15:0] p,
    input  logic [15:0] d,
    output logic        step_end
);

    logic [15:0] pre_cnt;
    logic [15:0] dur_cnt;

    assign step_end = en && (pre_cnt == p) && (dur_cnt == d);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so counter order is irrelevant.
        if (rst) begin
            pre_cnt <= '0;
            dur_cnt <= '0;
        end else if (clear || step_end) begin
            pre_cnt <= '0;
            dur_cnt <= '0;
        end else if (en) begin
            if (pre_cnt == p) begin
                pre_cnt <= '0;
                dur_cnt <= dur_cnt + 16'd1;
            end else begin
                pre_cnt <= pre_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/boa_gpio_seq.sv
// boa_gpio_seq: bus-programmable GPIO waveform sequencer driving the GPIO matrix ext/ext_oe inputs.
// Optional macro BOA_GPIO_SEQ_TRIG_EN adds a synchronised `trig` input and a CTRL ARM bit.
module boa_gpio_seq
    import boa_gpio_seq_pkg::*;
#(
    parameter logic [31:0] addr  = 32'h8000_0100,
    parameter int unsigned chans = 8,
    parameter int unsigned steps = 16
) (
    input  logic             clk,
    input  logic             rst,
`ifdef BOA_GPIO_SEQ_TRIG_EN
    input  logic             trig,
`endif
    boa_mem_bus.MEM          bus,
    output logic [chans-1:0] seq_out,
    output logic [chans-1:0] seq_oe,
    output logic             irq
);

    localparam int unsigned idx_w     = $clog2(steps);
    localparam logic [31:0] base_word = addr >> 2;
    localparam logic [5:0]  max_idx   = 6'(steps - 1);

    state_t      state, state_next;
    step_t       step_tbl [steps];
    step_t       cur;
    logic [5:0]  idx, load_idx, cfg_last, eff_last;
    logic [15:0] loops, loops_next, cfg_loops, prescale;
    logic        done, load, finish, step_end, arm, trig_start;

    logic [31:0] word_off, read_val;
    logic [8:0]  byte_off;
    logic        hit, wr, rd, step_ok, ctrl_wr, start_cmd, stop_cmd;

    // The 512-byte window need not be size-aligned, so decode by offset from the base.
    assign word_off  = bus.addr - base_word;
    assign byte_off  = {word_off[6:0], 2'b00};
    assign hit       = bus.valid && (word_off[31:7] == '0);
    assign wr        = hit && (bus.we == 4'hF);
    assign rd        = hit && (bus.we == 4'h0);
    assign step_ok   = (byte_off >= step_base_off) && (32'(byte_off[7:2]) < steps);
    assign ctrl_wr   = wr && (byte_off == ctrl_off);
    assign stop_cmd  = ctrl_wr && bus.wdata[ctrl_stop_bit];
    assign start_cmd = (ctrl_wr && bus.wdata[ctrl_start_bit]) || trig_start;
    assign eff_last  = (cfg_last > max_idx) ? max_idx : cfg_last;

    assign bus.ready = 1'b1;
    assign seq_out   = cur.value[chans-1:0];
    assign seq_oe    = cur.oe[chans-1:0];

    boa_gpio_seq_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (state == RUN),
        .clear    (load),
        .p        (prescale),
        .d        (cur.dur),
        .step_end (step_end)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        load       = 1'b0;
        load_idx   = idx;
        loops_next = loops;
        finish     = 1'b0;
        if (stop_cmd) begin
            state_next = IDLE;
        end else if (start_cmd) begin
            state_next = RUN;
            load       = 1'b1;
            load_idx   = '0;
            loops_next = cfg_loops;
        end else if (state == RUN && step_end) begin
            if (idx != eff_last) begin
                load     = 1'b1;
                load_idx = idx + 6'd1;
            end else if (loops != '0 || cfg_loops == 16'hFFFF) begin
                load     = 1'b1;
                load_idx = '0;
                if (cfg_loops != 16'hFFFF) loops_next = loops - 16'd1;
            end else begin
                state_next = IDLE;
                finish     = 1'b1;
            end
        end
    end

    always_comb begin
        read_val = '0;
        if (byte_off >= step_base_off) begin
            if (step_ok) read_val = step_tbl[byte_off[idx_w+1:2]];
        end else begin
            case (byte_off)
                ctrl_off: begin
                    read_val[ctrl_busy_bit] = (state == RUN);
                    read_val[ctrl_arm_bit]  = arm;
                    read_val[ctrl_done_bit] = done;
                end
                status_off:   read_val = {loops, 10'd0, idx};
                cfg_off:      read_val = {cfg_loops, 10'd0, cfg_last};
                prescale_off: read_val = {16'd0, prescale};
                default:      read_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the step table is flop-based and cleared on reset so a fresh table reads back as zero.
            step_tbl  <= '{default: '0};
            cur       <= '0;
            idx       <= '0;
            loops     <= '0;
            cfg_last  <= '0;
            cfg_loops <= '0;
            prescale  <= '0;
            done      <= 1'b0;
            irq       <= 1'b0;
            bus.rdata <= '0;
        end else begin
            if (load) begin
                idx <= load_idx;
                cur <= step_tbl[load_idx[idx_w-1:0]];
            end
            loops <= loops_next;
            irq   <= finish;
            if (finish)                                      done <= 1'b1;
            else if (ctrl_wr && bus.wdata[ctrl_done_bit])    done <= 1'b0;
            if (wr && byte_off == cfg_off) begin
                cfg_last  <= bus.wdata[5:0];
                cfg_loops <= bus.wdata[31:16];
            end
            if (wr && byte_off == prescale_off) prescale <= bus.wdata[15:0];
            if (wr && step_ok) step_tbl[byte_off[idx_w+1:2]] <= bus.wdata;
            bus.rdata <= rd ? read_val : '0;
        end
    end

`ifdef BOA_GPIO_SEQ_TRIG_EN
    // trig_sync[1:0] synchronise the pin; trig_sync[2] holds the previous level for edge detection.
    logic [2:0] trig_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_sync <= '0;
            arm       <= 1'b0;
        end else begin
            trig_sync <= {trig_sync[1:0], trig};
            if (ctrl_wr)         arm <= bus.wdata[ctrl_arm_bit];
            else if (trig_start) arm <= 1'b0;
        end
    end

    assign trig_start = arm && trig_sync[1] && !trig_sync[2] && (state == IDLE);
`else
    assign arm        = 1'b0;
    assign trig_start = 1'b0;
`endif

endmodule

// File: tb/tb_boa_gpio_seq.sv
// Self-checking bench for boa_gpio_seq: register vector table plus hand-timed sequence checks.
// Define BOA_GPIO_SEQ_TRIG_EN to also exercise the external trigger.
module tb_boa_gpio_seq;
    import boa_gpio_seq_pkg::*;

    localparam int unsigned chans = 8;
    localparam logic [31:0] base  = 32'h8000_0100;
    localparam int unsigned pres  = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [chans-1:0] seq_out;
    logic [chans-1:0] seq_oe;
    logic             irq;
`ifdef BOA_GPIO_SEQ_TRIG_EN
    logic             trig = 1'b0;
`endif

    boa_mem_bus bus_if ();

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    boa_gpio_seq #(.addr(base), .chans(chans), .steps(16)) dut (
        .clk     (clk),
        .rst     (rst),
`ifdef BOA_GPIO_SEQ_TRIG_EN
        .trig    (trig),
`endif
        .bus     (bus_if),
        .seq_out (seq_out),
        .seq_oe  (seq_oe),
        .irq     (irq)
    );

    typedef struct {
        logic [3:0]  we;
        logic [8:0]  off;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t  vecs[$];
    step_t model_tbl[3];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_outputs(string name, step_t exp, logic exp_irq);
        check($sformatf("%s out", name), 32'(seq_out), 32'(exp.value));
        check($sformatf("%s oe", name),  32'(seq_oe),  32'(exp.oe));
        check($sformatf("%s irq", name), 32'(irq),     32'(exp_irq));
    endtask

    // Caller is at a negedge; the access occupies exactly one clock.
    task automatic bus_write(logic [8:0] off, logic [31:0] data, logic [3:0] be = 4'hF);
        bus_if.valid = 1'b1;
        bus_if.we    = be;
        bus_if.addr  = (base + 32'(off)) >> 2;
        bus_if.wdata = data;
        @(negedge clk);
        bus_if.valid = 1'b0;
        bus_if.we    = 4'h0;
    endtask

    task automatic bus_read(logic [8:0] off, output logic [31:0] data);
        bus_if.valid = 1'b1;
        bus_if.we    = 4'h0;
        bus_if.addr  = (base + 32'(off)) >> 2;
        @(negedge clk);
        bus_if.valid = 1'b0;
        data = bus_if.rdata;
    endtask

    task automatic add_vec(logic [3:0] we, logic [8:0] off, logic [31:0] data, logic [31:0] exp, string name);
        vec_t v;
        v.we = we; v.off = off; v.data = data; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    // Expected step at cycle `cyc` of a pass through the three-step test table.
    function automatic step_t model_at(int unsigned cyc);
        int unsigned t = cyc;
        for (int i = 0; i < 3; i++) begin
            int unsigned h = (int'(model_tbl[i].dur) + 1) * (pres + 1);
            if (t < h) return model_tbl[i];
            t -= h;
        end
        return model_tbl[2];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rdv;
        step_t       zero_step;
        step_t       new0;
        int          irq_seen;

        zero_step    = '0;
        new0         = '{dur: 16'd0, oe: 8'hFF, value: 8'hAA};
        model_tbl[0] = '{dur: 16'd0, oe: 8'hFF, value: 8'h01};
        model_tbl[1] = '{dur: 16'd1, oe: 8'hFF, value: 8'h02};
        model_tbl[2] = '{dur: 16'd2, oe: 8'h0F, value: 8'h04};

        add_vec(4'h0, ctrl_off,     32'h0,         32'h0,         "reset ctrl");
        add_vec(4'h0, status_off,   32'h0,         32'h0,         "reset status");
        add_vec(4'h0, step_base_off,32'h0,         32'h0,         "reset step0");
        add_vec(4'h0, cfg_off,      32'h0,         32'h0,         "reset cfg");
        add_vec(4'h0, prescale_off, 32'h0,         32'h0,         "reset prescale");
        add_vec(4'hF, prescale_off, 32'h1,         32'h0,         "");
        add_vec(4'h0, prescale_off, 32'h0,         32'h1,         "prescale readback");
        add_vec(4'h3, prescale_off, 32'h55,        32'h0,         "");
        add_vec(4'h0, prescale_off, 32'h0,         32'h1,         "partial write ignored");
        add_vec(4'hF, cfg_off,      32'h0000_0002, 32'h0,         "");
        add_vec(4'h0, cfg_off,      32'h0,         32'h0000_0002, "cfg readback");
        add_vec(4'hF, 9'h100,       32'h0000_FF01, 32'h0,         "");
        add_vec(4'hF, 9'h104,       32'h0001_FF02, 32'h0,         "");
        add_vec(4'hF, 9'h108,       32'h0002_0F04, 32'h0,         "");
        add_vec(4'h0, 9'h104,       32'h0,         32'h0001_FF02, "step1 readback");
        add_vec(4'hF, 9'h140,       32'hDEAD_BEEF, 32'h0,         "");
        add_vec(4'h0, 9'h140,       32'h0,         32'h0,         "step16 out of range");
        add_vec(4'h0, 9'h010,       32'h0,         32'h0,         "unmapped offset");
        add_vec(4'hF, ctrl_off,     32'h100,       32'h0,         "");
        add_vec(4'h0, ctrl_off,     32'h0,         32'h0,         "ctrl idle");

        bus_if.valid = 1'b0;
        bus_if.we    = 4'h0;
        bus_if.addr  = '0;
        bus_if.wdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and register vectors
        check_outputs("reset", zero_step, 1'b0);
        foreach (vecs[i]) begin
            if (vecs[i].we == 4'h0) begin
                bus_read(vecs[i].off, rdv);
                check(vecs[i].name, rdv, vecs[i].exp);
            end else begin
                bus_write(vecs[i].off, vecs[i].data, vecs[i].we);
            end
        end

        // Single pass, L=0
        bus_write(ctrl_off, 32'h1);
        for (int c = 0; c < 12; c++) begin
            check_outputs($sformatf("pass c%0d", c), model_at(c), 1'b0);
            @(negedge clk);
        end
        check_outputs("single done", model_tbl[2], 1'b1);
        @(negedge clk);
        check_outputs("single after", model_tbl[2], 1'b0);
        bus_read(ctrl_off, rdv);
        check("single ctrl", rdv, 32'h100);
        bus_read(status_off, rdv);
        check("single status", rdv, 32'h0000_0002);

        // Two passes, L=1, streaming STATUS reads (rdata lags one cycle)
        bus_write(ctrl_off, 32'h100);
        bus_write(cfg_off, 32'h0001_0002);
        bus_write(ctrl_off, 32'h1);
        bus_if.valid = 1'b1;
        bus_if.we    = 4'h0;
        bus_if.addr  = (base + 32'(status_off)) >> 2;
        for (int c = 0; c < 24; c++) begin
            check_outputs($sformatf("loop c%0d", c), model_at(c % 12), 1'b0);
            if (c == 6)  check("loop status pass0", bus_if.rdata, 32'h0001_0001);
            if (c == 18) check("loop status pass1", bus_if.rdata, 32'h0000_0001);
            @(negedge clk);
        end
        bus_if.valid = 1'b0;
        check_outputs("loop done", model_tbl[2], 1'b1);
        @(negedge clk);
        check_outputs("loop after", model_tbl[2], 1'b0);

        // Infinite loop, then STOP
        bus_write(ctrl_off, 32'h100);
        bus_write(cfg_off, 32'hFFFF_0002);
        bus_write(ctrl_off, 32'h1);
        irq_seen = 0;
        for (int c = 0; c < 100; c++) begin
            if (irq) irq_seen++;
            @(negedge clk);
        end
        bus_write(ctrl_off, 32'h2);
        check_outputs("stop frozen", model_at(100 % 12), 1'b0);
        bus_read(ctrl_off, rdv);
        check("stop ctrl", rdv, 32'h0);
        for (int c = 0; c < 20; c++) begin
            if (irq) irq_seen++;
            @(negedge clk);
        end
        check_outputs("stop still frozen", model_at(100 % 12), 1'b0);
        check("stop no irq", 32'(irq_seen), 32'h0);

        // Table write mid-run, DONE set beats clear in the same cycle
        bus_write(cfg_off, 32'h0001_0002);
        bus_write(ctrl_off, 32'h1);
        bus_write(9'h100, 32'h0000_FFAA);
        check_outputs("old step0", model_tbl[0], 1'b0);
        repeat (11) @(negedge clk);
        check_outputs("new step0 c12", new0, 1'b0);
        @(negedge clk);
        check_outputs("new step0 c13", new0, 1'b0);
        @(negedge clk);
        check_outputs("new pass c14", model_tbl[1], 1'b0);
        repeat (9) @(negedge clk);
        bus_write(ctrl_off, 32'h100);
        check_outputs("set wins", model_tbl[2], 1'b1);
        bus_read(ctrl_off, rdv);
        check("set wins ctrl", rdv, 32'h100);
        bus_write(ctrl_off, 32'h103);
        bus_read(ctrl_off, rdv);
        check("start+stop idle", rdv, 32'h0);
        check_outputs("start+stop outputs", model_tbl[2], 1'b0);
        bus_write(9'h100, 32'h0000_FF01);

`ifdef BOA_GPIO_SEQ_TRIG_EN
        bus_write(cfg_off, 32'h0000_0002);
        bus_write(ctrl_off, 32'h4);
        bus_read(ctrl_off, rdv);
        check("arm readback", rdv, 32'h4);
        trig = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs("trig not early", model_tbl[2], 1'b0);
        @(negedge clk);
        check_outputs("trig c0", model_tbl[0], 1'b0);
        bus_read(ctrl_off, rdv);
        check("trig ctrl busy arm clear", rdv, 32'h1);
        trig = 1'b0;
        bus_write(ctrl_off, 32'h4);
        trig = 1'b1;
        for (int c = 2; c < 12; c++) begin
            check_outputs($sformatf("trig run c%0d", c), model_at(c), 1'b0);
            @(negedge clk);
        end
        check_outputs("trig done", model_tbl[2], 1'b1);
        bus_read(ctrl_off, rdv);
        check("trig ignored in run", rdv, 32'h104);
        bus_write(ctrl_off, 32'h100);
        trig = 1'b0;
`else
        bus_write(ctrl_off, 32'h4);
        bus_read(ctrl_off, rdv);
        check("arm absent", rdv, 32'h0);
`endif

        // Reset mid-run
        bus_write(cfg_off, 32'hFFFF_0002);
        bus_write(ctrl_off, 32'h1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_outputs("mid-run reset", zero_step, 1'b0);
        rst = 1'b0;
        bus_read(ctrl_off, rdv);
        check("reset ctrl again", rdv, 32'h0);
        bus_read(cfg_off, rdv);
        check("reset cfg again", rdv, 32'h0);
        bus_read(9'h104, rdv);
        check("reset table", rdv, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
